// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode 7-segment driver with per-frame snapshot.
// Optional leading-zero suppression when SEG7_ZERO_BLANK_EN is defined.
module seg7_scan #(
  parameter int SCAN_CNT_W = 16,
  parameter int DEAD       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] disp_num,
  input  logic [3:0]  point,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [SCAN_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SCAN_CNT_W-1:0] DEAD_V  = SCAN_CNT_W'(DEAD);

  logic [SCAN_CNT_W-1:0] cnt;
  logic [1:0]            idx;
  logic [15:0]           sh_num;
  logic [3:0]            sh_point;
  logic [3:0]            sh_blank;

  logic       tick;
  logic       dead;
  logic       dark;
  logic [3:0] zb;
  logic [3:0] nib;
  logic [6:0] pat;
  logic [3:0] an_d;
  logic [7:0] seg_d;

  assign tick = (cnt == CNT_MAX);
  assign nib  = sh_num[{idx, 2'b00} +: 4];

  generate
    if (DEAD == 0) begin : g_nodead
      assign dead = 1'b0;
    end else begin : g_dead
      assign dead = (cnt < DEAD_V);
    end
  endgenerate

`ifdef SEG7_ZERO_BLANK_EN
  // digit i goes dark when it and every digit left of it is zero
  always_comb begin
    zb    = '0;
    zb[3] = (sh_num[15:12] == 4'h0);
    zb[2] = zb[3] && (sh_num[11:8] == 4'h0);
    zb[1] = zb[2] && (sh_num[7:4] == 4'h0);
  end
`else
  assign zb = '0;
`endif

  always_comb begin
    pat = 7'h7F;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
  end

  assign dark = dead | sh_blank[idx] | zb[idx];

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 8'hFF;
    if (!dark) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = {~sh_point[idx], pat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh_num     <= 16'h0000;
      sh_point   <= 4'h0;
      sh_blank   <= 4'h0;
      an         <= 4'b1111;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= 1'b0;
      if (tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          sh_num     <= disp_num;
          sh_point   <= point;
          sh_blank   <= blank;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule
